// File: rtl/pipebomb_pkg.sv
// Shared pipebomb router types: resolved ITCH instruction, price level and
// top-of-book record, plus side encodings used by the level book.
package pipebomb_pkg;

    localparam int PRICE_BITS   = 32;
    localparam int QTY_BITS     = 32;
    localparam int OID_BITS     = 64;
    localparam int TOB_SEQ_BITS = 16;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    typedef enum logic [3:0] {
        ITCH_NOP     = 4'd0,
        ITCH_ADD     = 4'd1,
        ITCH_CANCEL  = 4'd2,
        ITCH_EXECUTE = 4'd3,
        ITCH_DELETE  = 4'd4,
        ITCH_REPLACE = 4'd5
    } itch_op_t;

    typedef struct packed {
        itch_op_t              opcode;
        logic [OID_BITS-1:0]   order_id;
        logic                  side;
        logic [PRICE_BITS-1:0] price;
        logic [QTY_BITS-1:0]   quantity;
        logic                  valid;
    } inst_t;

    typedef struct packed {
        logic                  valid;
        logic [PRICE_BITS-1:0] price;
        logic [QTY_BITS-1:0]   qty;
    } level_t;

    typedef struct packed {
        logic                    bid_valid;
        logic [PRICE_BITS-1:0]   bid_price;
        logic [QTY_BITS-1:0]     bid_qty;
        logic                    ask_valid;
        logic [PRICE_BITS-1:0]   ask_price;
        logic [QTY_BITS-1:0]     ask_qty;
        logic                    crossed;
        logic [TOB_SEQ_BITS-1:0] seq;
    } tob_t;

    // Only instructions that touch a level produce a top-of-book record.
    function automatic logic emits_record(input inst_t i);
        return i.valid && (i.opcode inside {ITCH_ADD, ITCH_CANCEL, ITCH_EXECUTE, ITCH_DELETE});
    endfunction

endpackage

// File: rtl/router_levelbook_side.sv
// One side of the level book: LEVELS sorted entries, best at index 0.
// Optional miss/sat pulse ports exist only when LEVELBOOK_STATS_EN is defined.
module router_levelbook_side
    import pipebomb_pkg::*;
#(
    parameter int LEVELS    = 8,
    parameter bit ASCENDING = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  apply,
    input  itch_op_t              op,
    input  logic [PRICE_BITS-1:0] price,
    input  logic [QTY_BITS-1:0]   qty,
`ifdef LEVELBOOK_STATS_EN
    output logic                  miss,
    output logic                  sat,
`endif
    output level_t                best,
    output logic                  drop,
    output logic                  evict
);

    level_t tbl     [LEVELS];
    level_t tbl_nxt [LEVELS];

    logic [LEVELS-1:0]   hit;
    logic [LEVELS-1:0]   ahead;
    logic [LEVELS-1:0]   past;
    logic                found;
    logic                is_add;
    logic                is_dec;
    logic [QTY_BITS-1:0] hit_qty;
    logic [QTY_BITS:0]   sum;
    logic [QTY_BITS-1:0] add_qty;
    logic [QTY_BITS-1:0] dec_qty;
    level_t              new_lvl;

    // ahead[] is a prefix mask of valid entries strictly better than price;
    // past[] marks the matching entry and everything worse than it.
    always_comb begin
        logic acc;
        acc     = 1'b0;
        hit_qty = '0;
        for (int i = 0; i < LEVELS; i++) begin
            hit[i]   = tbl[i].valid && (tbl[i].price == price);
            ahead[i] = tbl[i].valid && (ASCENDING ? (tbl[i].price < price) : (tbl[i].price > price));
            acc      = acc | hit[i];
            past[i]  = acc;
            if (hit[i]) begin
                hit_qty = hit_qty | tbl[i].qty;
            end
        end
        found         = |hit;
        is_add        = (op == ITCH_ADD);
        is_dec        = (op inside {ITCH_CANCEL, ITCH_EXECUTE, ITCH_DELETE});
        sum           = {1'b0, hit_qty} + {1'b0, qty};
        add_qty       = sum[QTY_BITS] ? '1 : sum[QTY_BITS-1:0];
        dec_qty       = (qty >= hit_qty) ? '0 : (hit_qty - qty);
        new_lvl       = '0;
        new_lvl.valid = 1'b1;
        new_lvl.price = price;
        new_lvl.qty   = qty;
    end

    always_comb begin
        for (int i = 0; i < LEVELS; i++) begin
            tbl_nxt[i] = tbl[i];
        end
        drop  = 1'b0;
        evict = 1'b0;
        if (apply && is_add && (qty != '0)) begin
            if (found) begin
                for (int i = 0; i < LEVELS; i++) begin
                    if (hit[i]) begin
                        tbl_nxt[i].qty = add_qty;
                    end
                end
            end else if (ahead[LEVELS-1]) begin
                drop = 1'b1;
            end else begin
                // Insert at the first slot not ahead of the new price; the
                // worst entry falls off the end when the table was full.
                evict = tbl[LEVELS-1].valid;
                if (!ahead[0]) begin
                    tbl_nxt[0] = new_lvl;
                end
                for (int i = 1; i < LEVELS; i++) begin
                    if (!ahead[i]) begin
                        tbl_nxt[i] = ahead[i-1] ? new_lvl : tbl[i-1];
                    end
                end
            end
        end else if (apply && is_dec && found) begin
            if (dec_qty != '0) begin
                for (int i = 0; i < LEVELS; i++) begin
                    if (hit[i]) begin
                        tbl_nxt[i].qty = dec_qty;
                    end
                end
            end else begin
                for (int i = 0; i < LEVELS - 1; i++) begin
                    if (past[i]) begin
                        tbl_nxt[i] = tbl[i+1];
                    end
                end
                tbl_nxt[LEVELS-1] = '0;
            end
        end
    end

`ifdef LEVELBOOK_STATS_EN
    assign miss = apply && is_dec && !found;
    assign sat  = apply && is_add && (qty != '0) && found && sum[QTY_BITS];
`endif

    assign best = tbl_nxt[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LEVELS; i++) begin
                tbl[i] <= '0;
            end
        end else if (apply) begin
            tbl <= tbl_nxt;
        end
    end

endmodule

// File: rtl/router_levelbook.sv
// Top-of-book aggregator: S0 input register, S1 table update + record register.
// Statistics counters are built only when LEVELBOOK_STATS_EN is defined.
module router_levelbook
    import pipebomb_pkg::*;
#(
    parameter int LEVELS   = 8,
    parameter int SEQ_BITS = 16,
    parameter int CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_v,
    output logic                in_r,
    input  inst_t               in_d,
    output logic                out_v,
    input  logic                out_r,
    output tob_t                out_d,
    output logic [1:0]          stale,
    output logic [CNT_BITS-1:0] miss_cnt,
    output logic [CNT_BITS-1:0] drop_cnt,
    output logic [CNT_BITS-1:0] sat_cnt
);

    logic                  s0_v;
    logic                  s0_rec;
    logic                  s0_side;
    itch_op_t              s0_op;
    logic [PRICE_BITS-1:0] s0_price;
    logic [QTY_BITS-1:0]   s0_qty;

    logic                  adv;
    logic                  commit;
    logic [1:0]            apply;
    logic [SEQ_BITS-1:0]   seq;
    level_t                bid;
    level_t                ask;
    logic [1:0]            drop_ev;
    logic [1:0]            evict_ev;
    tob_t                  rec_nxt;

    // Silent instructions never wait on the output, so they can't stall S0.
    assign adv    = s0_v && (!s0_rec || !out_v || out_r);
    assign in_r   = !s0_v || adv;
    assign commit = adv && s0_rec;
    assign apply  = {commit && (s0_side == SIDE_SELL), commit && (s0_side == SIDE_BUY)};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_v     <= 1'b0;
            s0_rec   <= 1'b0;
            s0_side  <= SIDE_BUY;
            s0_op    <= ITCH_NOP;
            s0_price <= '0;
            s0_qty   <= '0;
        end else if (in_r) begin
            s0_v     <= in_v;
            s0_rec   <= emits_record(in_d);
            s0_side  <= in_d.side;
            s0_op    <= in_d.opcode;
            s0_price <= in_d.price;
            s0_qty   <= in_d.quantity;
        end
    end

`ifdef LEVELBOOK_STATS_EN
    logic [1:0] miss_ev;
    logic [1:0] sat_ev;
`endif

    router_levelbook_side #(.LEVELS(LEVELS), .ASCENDING(1'b0)) u_buy (
        .clk   (clk),
        .rstn  (rstn),
        .apply (apply[0]),
        .op    (s0_op),
        .price (s0_price),
        .qty   (s0_qty),
`ifdef LEVELBOOK_STATS_EN
        .miss  (miss_ev[0]),
        .sat   (sat_ev[0]),
`endif
        .best  (bid),
        .drop  (drop_ev[0]),
        .evict (evict_ev[0])
    );

    router_levelbook_side #(.LEVELS(LEVELS), .ASCENDING(1'b1)) u_sell (
        .clk   (clk),
        .rstn  (rstn),
        .apply (apply[1]),
        .op    (s0_op),
        .price (s0_price),
        .qty   (s0_qty),
`ifdef LEVELBOOK_STATS_EN
        .miss  (miss_ev[1]),
        .sat   (sat_ev[1]),
`endif
        .best  (ask),
        .drop  (drop_ev[1]),
        .evict (evict_ev[1])
    );

    // Record reflects both tables after this cycle's update; empty sides read as zero.
    always_comb begin
        rec_nxt           = '0;
        rec_nxt.bid_valid = bid.valid;
        rec_nxt.bid_price = bid.valid ? bid.price : '0;
        rec_nxt.bid_qty   = bid.valid ? bid.qty : '0;
        rec_nxt.ask_valid = ask.valid;
        rec_nxt.ask_price = ask.valid ? ask.price : '0;
        rec_nxt.ask_qty   = ask.valid ? ask.qty : '0;
        rec_nxt.crossed   = bid.valid && ask.valid && (bid.price >= ask.price);
        rec_nxt.seq       = seq;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_v <= 1'b0;
            out_d <= '0;
            seq   <= '0;
        end else if (commit) begin
            out_v <= 1'b1;
            out_d <= rec_nxt;
            seq   <= seq + 1'b1;
        end else if (out_r) begin
            out_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stale <= 2'b00;
        end else begin
            stale <= stale | drop_ev | evict_ev;
        end
    end

`ifdef LEVELBOOK_STATS_EN
    function automatic logic [CNT_BITS-1:0] bump(input logic [CNT_BITS-1:0] c, input logic en);
        return (en && (c != '1)) ? (c + 1'b1) : c;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            miss_cnt <= '0;
            drop_cnt <= '0;
            sat_cnt  <= '0;
        end else begin
            miss_cnt <= bump(miss_cnt, |miss_ev);
            drop_cnt <= bump(drop_cnt, |drop_ev);
            sat_cnt  <= bump(sat_cnt, |sat_ev);
        end
    end
`else
    assign miss_cnt = '0;
    assign drop_cnt = '0;
    assign sat_cnt  = '0;
`endif

endmodule
